// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RISC-V datapath.
// This module sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
// Per-state datapath strobes are decoded from the registered state and the latched opcode.
// FETCH and MEM wait on a memory ready handshake.
// That wait is bounded: if memory never answers, the FSM raises MemFault and refetches.
module multicycle_control #(
  parameter int ALUOP_W       = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int TIMEOUT       = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         instruction,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               Branch,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegWrite,
  output logic               Illegal,
  output logic               MemFault,
  output logic [2:0]         state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [6:0]       op_reg, op_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       aluop3;

  logic mem_wait_state;
  logic done;
  logic timeout_hit;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH);
  endfunction

  // Memory-wait qualifiers.
  // Without the handshake, every access completes in its first cycle.
  // In that case the timeout can never trigger.
  assign mem_wait_state = (state_reg == FETCH) || (state_reg == MEM);
  assign done           = !MEM_HANDSHAKE || mem_ready;
  assign timeout_hit    = MEM_HANDSHAKE && mem_wait_state && !mem_ready &&
                          (cnt_reg == CNT_W'(TIMEOUT));

  // State, latched opcode and wait counter registers (async active-low reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= 7'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Wait counter.
  // It counts only while FETCH/MEM stalls in place.
  // Any state change, or a timeout re-entry into FETCH, clears it.
  always_comb begin
    cnt_next = '0;
    if (mem_wait_state && (state_next == state_reg) && !timeout_hit)
      cnt_next = cnt_reg + CNT_W'(1);
  end

  // Next-state logic and Moore strobe decode.
  // The completion/timeout gating is applied on top of the Moore decode.
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    aluop3     = 3'b000;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;
    MemFault   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        if (timeout_hit) begin
          // Memory never answered: drop every strobe and restart the fetch.
          MemFault   = 1'b1;
          state_next = FETCH;
        end else begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (done) begin
            PCWrite    = 1'b1;
            IRWrite    = 1'b1;
            state_next = DECODE;
          end
        end
      end

      DECODE: begin
        // The ALU precomputes the branch target while the opcode is latched.
        ALUSrcB = 2'b10;
        op_next = instruction;
        if (op_supported(instruction)) begin
          state_next = EXEC;
        end else begin
          Illegal    = 1'b1;
          state_next = FETCH;
        end
      end

      EXEC: begin
        ALUSrcA    = 1'b1;
        state_next = FETCH;
        unique case (op_reg)
          OP_LOAD, OP_STORE: begin
            ALUSrcB    = 2'b10;
            state_next = MEM;
          end
          OP_RTYPE: begin
            ALUSrcB    = 2'b00;
            aluop3     = 3'b010;
            state_next = WB;
          end
          OP_ITYPE: begin
            ALUSrcB    = 2'b10;
            aluop3     = 3'b011;
            state_next = WB;
          end
          OP_BRANCH: begin
            ALUSrcB = 2'b00;
            aluop3  = 3'b001;
            Branch  = 1'b1;
          end
          default: begin
            ALUSrcA = 1'b0;
          end
        endcase
      end

      MEM: begin
        if (timeout_hit) begin
          MemFault   = 1'b1;
          state_next = FETCH;
        end else begin
          // Strobes hold until the memory completes the access.
          IorD     = 1'b1;
          MemRead  = (op_reg == OP_LOAD);
          MemWrite = (op_reg == OP_STORE);
          if (done)
            state_next = (op_reg == OP_LOAD) ? WB : FETCH;
        end
      end

      WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = (op_reg == OP_LOAD);
        state_next = FETCH;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ALUOp is zero-extended from the 3-bit operation code.
  always_comb begin
    ALUOp       = '0;
    ALUOp[2:0]  = aluop3;
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// A handshake instance and a no-handshake instance share the clock, reset and opcode.
// Per-cycle expected vectors are queued alongside the stimulus.
// Each queued vector is compared when the DUT presents that cycle's outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] instruction = 7'd0;
  logic       mem_ready = 1'b0;
  logic       mem_ready_n = 1'b0;

  logic       PCWrite, Branch, IRWrite, IorD, MemRead, MemWrite, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp, state_o;
  logic       RegWrite, Illegal, MemFault;

  logic       PCWrite_n, Branch_n, IRWrite_n, IorD_n, MemRead_n, MemWrite_n, MemtoReg_n, ALUSrcA_n;
  logic [1:0] ALUSrcB_n;
  logic [2:0] ALUOp_n, state_o_n;
  logic       RegWrite_n, Illegal_n, MemFault_n;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, br, irw, iord, mr, mw, m2r, asa;
    logic [1:0] asb;
    logic [2:0] aluop;
    logic       rw, ill, mf;
  } obs_t;

  typedef struct {
    logic       ready;
    logic [6:0] instr;
    obs_t       exp;
  } item_t;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, BAD = 7'b1111111;

  obs_t  o_main, o_nh;
  item_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .MEM_HANDSHAKE(1'b1), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .Illegal(Illegal),
    .MemFault(MemFault), .state_o(state_o));

  multicycle_control #(.ALUOP_W(3), .MEM_HANDSHAKE(1'b0), .TIMEOUT(15)) dut_nh (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready_n),
    .PCWrite(PCWrite_n), .Branch(Branch_n), .IRWrite(IRWrite_n), .IorD(IorD_n),
    .MemRead(MemRead_n), .MemWrite(MemWrite_n), .MemtoReg(MemtoReg_n), .ALUSrcA(ALUSrcA_n),
    .ALUSrcB(ALUSrcB_n), .ALUOp(ALUOp_n), .RegWrite(RegWrite_n), .Illegal(Illegal_n),
    .MemFault(MemFault_n), .state_o(state_o_n));

  assign o_main = {state_o, PCWrite, Branch, IRWrite, IorD, MemRead, MemWrite, MemtoReg,
                   ALUSrcA, ALUSrcB, ALUOp, RegWrite, Illegal, MemFault};
  assign o_nh   = {state_o_n, PCWrite_n, Branch_n, IRWrite_n, IorD_n, MemRead_n, MemWrite_n,
                   MemtoReg_n, ALUSrcA_n, ALUSrcB_n, ALUOp_n, RegWrite_n, Illegal_n, MemFault_n};

  // Expected per-state output templates, taken from the state tables.
  function automatic obs_t f_idle();
    f_idle = '0;
  endfunction

  function automatic obs_t f_fetch(input logic done);
    f_fetch = '0; f_fetch.st = 3'd1; f_fetch.mr = 1'b1; f_fetch.asb = 2'b01;
    f_fetch.pcw = done; f_fetch.irw = done;
  endfunction

  function automatic obs_t f_decode(input logic ill);
    f_decode = '0; f_decode.st = 3'd2; f_decode.asb = 2'b10; f_decode.ill = ill;
  endfunction

  function automatic obs_t f_exec(input logic [6:0] op);
    f_exec = '0; f_exec.st = 3'd3; f_exec.asa = 1'b1;
    case (op)
      LD, ST:  f_exec.asb = 2'b10;
      RT:      begin f_exec.asb = 2'b00; f_exec.aluop = 3'b010; end
      IT:      begin f_exec.asb = 2'b10; f_exec.aluop = 3'b011; end
      default: begin f_exec.asb = 2'b00; f_exec.aluop = 3'b001; f_exec.br = 1'b1; end
    endcase
  endfunction

  function automatic obs_t f_mem(input logic is_load);
    f_mem = '0; f_mem.st = 3'd4; f_mem.iord = 1'b1;
    f_mem.mr = is_load; f_mem.mw = !is_load;
  endfunction

  function automatic obs_t f_wb(input logic is_load);
    f_wb = '0; f_wb.st = 3'd5; f_wb.rw = 1'b1; f_wb.m2r = is_load;
  endfunction

  function automatic obs_t f_fault(input logic [2:0] st);
    f_fault = '0; f_fault.st = st; f_fault.mf = 1'b1;
  endfunction

  task automatic push(input logic ready, input logic [6:0] instr, input obs_t exp);
    item_t it;
    it.ready = ready; it.instr = instr; it.exp = exp;
    q.push_back(it);
  endtask

  // Asynchronous reset: outputs must be zero without any clock edge.
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; instruction = 7'd0;
    #1;
    n_cmp++;
    if (o_main !== f_idle()) begin
      n_bad++; $display("FAIL reset_async main: got %b want %b", o_main, f_idle());
    end
    n_cmp++;
    if (o_nh !== f_idle()) begin
      n_bad++; $display("FAIL reset_async nh: got %b want %b", o_nh, f_idle());
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_rtype();
    item_t it;
    int cyc = 0;
    push(1'b1, RT, f_idle());
    push(1'b1, RT, f_fetch(1'b1));
    push(1'b1, RT, f_decode(1'b0));
    push(1'b1, RT, f_exec(RT));
    push(1'b1, RT, f_wb(1'b0));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL rtype cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("rtype: %0d cycles checked", cyc);
  endtask

  task automatic test_load_wait();
    item_t it;
    int cyc = 0;
    push(1'b1, LD, f_fetch(1'b1));
    push(1'b1, LD, f_decode(1'b0));
    push(1'b1, LD, f_exec(LD));
    push(1'b0, LD, f_mem(1'b1));
    push(1'b0, LD, f_mem(1'b1));
    push(1'b1, LD, f_mem(1'b1));
    push(1'b1, LD, f_wb(1'b1));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL load_wait cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("load_wait: %0d cycles checked", cyc);
  endtask

  task automatic test_store_branch();
    item_t it;
    int cyc = 0;
    push(1'b1, ST, f_fetch(1'b1));
    push(1'b1, ST, f_decode(1'b0));
    push(1'b1, ST, f_exec(ST));
    push(1'b1, ST, f_mem(1'b0));
    push(1'b1, BR, f_fetch(1'b1));
    push(1'b1, BR, f_decode(1'b0));
    push(1'b1, BR, f_exec(BR));
    push(1'b1, IT, f_fetch(1'b1));
    push(1'b1, IT, f_decode(1'b0));
    push(1'b1, IT, f_exec(IT));
    push(1'b1, IT, f_wb(1'b0));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL store_branch cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("store_branch_itype: %0d cycles checked", cyc);
  endtask

  task automatic test_illegal();
    item_t it;
    int cyc = 0;
    push(1'b1, BAD, f_fetch(1'b1));
    push(1'b1, BAD, f_decode(1'b1));
    push(1'b1, BAD, f_fetch(1'b1));
    push(1'b1, RT, f_decode(1'b0));
    push(1'b1, RT, f_exec(RT));
    push(1'b1, RT, f_wb(1'b0));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL illegal cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("illegal: %0d cycles checked", cyc);
  endtask

  // First FETCH stall runs into the timeout.
  // The second stall completes exactly on the 16th cycle, so no fault is raised.
  task automatic test_timeout_fetch();
    item_t it;
    int cyc = 0;
    for (int i = 0; i < 15; i++) push(1'b0, RT, f_fetch(1'b0));
    push(1'b0, RT, f_fault(3'd1));
    for (int i = 0; i < 15; i++) push(1'b0, RT, f_fetch(1'b0));
    push(1'b1, RT, f_fetch(1'b1));
    push(1'b1, RT, f_decode(1'b0));
    push(1'b1, RT, f_exec(RT));
    push(1'b1, RT, f_wb(1'b0));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL timeout_fetch cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("timeout_fetch: %0d cycles checked", cyc);
  endtask

  task automatic test_timeout_mem();
    item_t it;
    int cyc = 0;
    push(1'b1, LD, f_fetch(1'b1));
    push(1'b1, LD, f_decode(1'b0));
    push(1'b1, LD, f_exec(LD));
    for (int i = 0; i < 15; i++) push(1'b0, LD, f_mem(1'b1));
    push(1'b0, LD, f_fault(3'd4));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL timeout_mem cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("timeout_mem: %0d cycles checked", cyc);
  endtask

  // Reset is dropped during a load's WB cycle.
  task automatic test_mid_reset();
    item_t it;
    int cyc = 0;
    push(1'b1, LD, f_fetch(1'b1));
    push(1'b1, LD, f_decode(1'b0));
    push(1'b1, LD, f_exec(LD));
    push(1'b1, LD, f_mem(1'b1));
    push(1'b1, LD, f_wb(1'b1));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL mid_reset pre cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      if (q.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_main !== f_idle()) begin
      n_bad++; $display("FAIL mid_reset async: got %b want %b", o_main, f_idle());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (o_main !== f_idle()) begin
      n_bad++; $display("FAIL mid_reset held: got %b want %b", o_main, f_idle());
    end
    rst_n = 1'b1;
    push(1'b1, RT, f_idle());
    push(1'b1, RT, f_fetch(1'b1));
    push(1'b1, RT, f_decode(1'b0));
    push(1'b1, RT, f_exec(RT));
    push(1'b1, RT, f_wb(1'b0));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_main !== it.exp) begin
        n_bad++; $display("FAIL mid_reset post cyc%0d: got %b want %b", cyc, o_main, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("mid_reset: %0d cycles checked", cyc);
  endtask

  // The no-handshake instance must finish a load in 5 cycles with mem_ready held low.
  task automatic test_nohandshake();
    item_t it;
    int cyc = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(1'b0, LD, f_idle());
    push(1'b0, LD, f_fetch(1'b1));
    push(1'b0, LD, f_decode(1'b0));
    push(1'b0, LD, f_exec(LD));
    push(1'b0, LD, f_mem(1'b1));
    push(1'b0, LD, f_wb(1'b1));
    push(1'b0, ST, f_fetch(1'b1));
    push(1'b0, ST, f_decode(1'b0));
    push(1'b0, ST, f_exec(ST));
    push(1'b0, ST, f_mem(1'b0));
    push(1'b0, ST, f_fetch(1'b1));
    while (q.size() > 0) begin
      it = q.pop_front(); mem_ready = it.ready; mem_ready_n = it.ready; instruction = it.instr;
      @(negedge clk);
      n_cmp++;
      if (o_nh !== it.exp) begin
        n_bad++; $display("FAIL nohandshake cyc%0d: got %b want %b", cyc, o_nh, it.exp);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("nohandshake: %0d cycles checked", cyc);
  endtask

  initial begin
    #2;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_branch();
    test_illegal();
    test_timeout_fetch();
    test_timeout_mem();
    test_mid_reset();
    test_nohandshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the RISC-V datapath. It replaces single-cycle opcode decoding with a sequenced FETCH/DECODE/EXEC/MEM/WB controller.
- It drives per-state datapath strobes and waits on a memory ready handshake, with a bounded timeout.
- It flags illegal opcodes and memory faults. It sits between the instruction register opcode field and the shared memory/ALU/register-file datapath.

Parameters:
- ALUOP_W, 3, width of ALUOp output (must be >= 3); upper bits zero.
- MEM_HANDSHAKE, 1, 1 = FETCH/MEM wait for mem_ready; 0 = memory assumed single-cycle and mem_ready is ignored.
- TIMEOUT, 15, maximum wait cycles for mem_ready before MemFault (must be >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instruction  input  7  opcode field from instruction register, valid in DECODE
- mem_ready  input  1  memory access complete this cycle
- PCWrite  output  1  unconditional PC update (PC+4 at end of FETCH)
- Branch  output  1  conditional PC update in branch EXEC
- IRWrite  output  1  load instruction register
- IorD  output  1  0 = memory address from PC, 1 = from ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- MemtoReg  output  1  write-back source 1 = memory data, 0 = ALUOut
- ALUSrcA  output  1  0 = PC, 1 = rs1
- ALUSrcB  output  2  00 = rs2, 01 = const 4, 10 = immediate
- ALUOp  output  ALUOP_W  000 add, 001 branch compare, 010 R-type funct, 011 I-type funct
- RegWrite  output  1  register-file write
- Illegal  output  1  one-cycle pulse on unsupported opcode
- MemFault  output  1  one-cycle pulse on mem_ready timeout
- state_o  output  3  current state, for debug

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- rst_n low: state is IDLE, op_q=0, wait counter=0, and all outputs are 0 immediately (asynchronous). IDLE lasts one cycle after release, then FETCH.
- Outputs are Moore outputs: combinational decode of the registered state and the latched opcode op_q. Outputs are 0 in any field not listed for a state.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000.
  - PCWrite and IRWrite assert only in the completing cycle, i.e. mem_ready=1, or always if MEM_HANDSHAKE=0.
  - Transition: to DECODE on completion, otherwise stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=10, ALUOp=000 (branch target precompute).
  - op_q <= instruction.
  - Supported opcodes go to EXEC. Any other opcode pulses Illegal and goes to FETCH.
- EXEC, by op_q:
  - 0000011 load: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state MEM.
  - 0100011 store: same controls as load. Next state MEM.
  - 0110011 R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next state WB.
  - 0010011 I-type ALU: ALUSrcA=1, ALUSrcB=10, ALUOp=011. Next state WB.
  - 1100011 branch: ALUSrcA=1, ALUSrcB=00, ALUOp=001, Branch=1. Next state FETCH.
- MEM:
  - Outputs: IorD=1. Load asserts MemRead=1; store asserts MemWrite=1.
  - Strobes are held until completion.
  - Load completes to WB; store completes to FETCH.
- WB:
  - Outputs: RegWrite=1, MemtoReg=1 for load, 0 otherwise.
  - Next state FETCH.
- Latency, counted FETCH to next FETCH with zero-wait memory:
  - branch 3 cycles
  - store 4 cycles
  - R-type and I-type 4 cycles
  - load 5 cycles
  - each wait cycle in FETCH or MEM adds 1.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle those states stay without mem_ready.
  - When the counter reaches TIMEOUT with mem_ready still 0: pulse MemFault, drop all strobes, go to FETCH. Entry into FETCH clears the counter.
  - mem_ready=1 in the same cycle the counter reaches TIMEOUT counts as completion, with no fault.
  - With MEM_HANDSHAKE=0 the counter stays 0 and MemFault is never asserted.
- mem_ready is ignored outside FETCH and MEM.
- op_q holds its value from DECODE until the next DECODE.
- Reset asserted mid-instruction: immediate return to IDLE with all strobes 0. No partial RegWrite or MemWrite may occur after the reset edge.

Test Plan:
- Reset release, MEM_HANDSHAKE=1, mem_ready=1 constant, instruction=0110011 -> state sequence IDLE, FETCH, DECODE, EXEC (ALUOp=010, ALUSrcB=00), WB (RegWrite=1, MemtoReg=0), FETCH. PCWrite and IRWrite high exactly 1 cycle.
- Load 0000011 with mem_ready low for 2 cycles in MEM -> MemRead=1 and IorD=1 held for 3 cycles, then WB with MemtoReg=1. Total 7 cycles FETCH to FETCH.
- Store 0100011 then branch 1100011 -> store: MemWrite=1 in MEM, RegWrite never 1. Branch: Branch=1 and ALUOp=001 in EXEC, returns to FETCH after 3 cycles.
- instruction=1111111 in DECODE -> Illegal high 1 cycle, next state FETCH, no RegWrite, MemRead or MemWrite in between.
- TIMEOUT=15, mem_ready held 0 in FETCH -> MemFault pulses on the 16th cycle in FETCH, and the counter restarts. Repeat with mem_ready=1 on exactly the 16th cycle -> no fault, state goes to DECODE.
- rst_n dropped during WB of a load -> RegWrite goes 0 asynchronously, state_o=0. After release the sequence restarts IDLE, FETCH. With MEM_HANDSHAKE=0 and mem_ready=0 the load still completes in 5 cycles.
